// File: rtl/line_follow_ctrl.sv
// rtl/line_follow_ctrl.sv - three-sensor line follower: hysteresis classifier, motion FSM, node detect
module line_follow_ctrl #(
    parameter int ADC_W     = 12,
    parameter int TH_HI     = 500,
    parameter int TH_LO     = 200,
    parameter int DUTY_W    = 4,
    parameter int DUTY_FWD  = 8,
    parameter int DUTY_FAST = 7,
    parameter int DUTY_SLOW = 5,
    parameter int NODE_DEB  = 4,
    parameter int NODE_HOLD = 8,
    parameter int LOST_TO   = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [ADC_W-1:0]  left,
    input  logic [ADC_W-1:0]  middle,
    input  logic [ADC_W-1:0]  right,
    output logic              m1_a,
    output logic              m1_b,
    output logic              m2_a,
    output logic              m2_b,
    output logic [DUTY_W-1:0] dc1,
    output logic [DUTY_W-1:0] dc2,
    output logic              node_flag,
    output logic [CNT_W-1:0]  node_count,
    output logic              lost,
    output logic [2:0]        state
);
    localparam int DW = $clog2(NODE_DEB + 1);
    localparam int HW = $clog2(NODE_HOLD + 1);
    localparam int LW = $clog2(LOST_TO + 1);
    localparam logic [ADC_W-1:0]  HI   = ADC_W'(TH_HI);
    localparam logic [ADC_W-1:0]  LO   = ADC_W'(TH_LO);
    localparam logic [DW-1:0]     DEB_MAX  = DW'(NODE_DEB);
    localparam logic [HW-1:0]     HOLD_MAX = HW'(NODE_HOLD);
    localparam logic [LW-1:0]     LOST_MAX = LW'(LOST_TO);
    localparam logic [DUTY_W-1:0] D_FWD  = DUTY_W'(DUTY_FWD);
    localparam logic [DUTY_W-1:0] D_FAST = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] D_SLOW = DUTY_W'(DUTY_SLOW);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_TURN_L = 3'd2,
        S_TURN_R = 3'd3,
        S_NODE   = 3'd4,
        S_LOST   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              l_q, m_q, r_q, l_d, m_d, r_d;
    logic [2:0]        pat;
    logic [DW-1:0]     deb_q, deb_d, deb_inc;
    logic [HW-1:0]     hold_q, hold_d, hold_inc;
    logic [LW-1:0]     lost_q, lost_d, lost_inc;
    logic [CNT_W-1:0]  count_d;
    logic              flag_d;
    logic [3:0]        pins_d;
    logic [DUTY_W-1:0] dc1_d, dc2_d;

    assign deb_inc  = deb_q + 1'b1;
    assign hold_inc = hold_q + 1'b1;
    assign lost_inc = lost_q + 1'b1;
    assign state    = state_q;
    assign pat      = {l_d, m_d, r_d};

    // Hysteresis classifier: readings between (and at) the thresholds keep the old bit
    always_comb begin
        l_d = l_q;
        m_d = m_q;
        r_d = r_q;
        if (sample_valid) begin
            if (left > HI)        l_d = 1'b1;
            else if (left < LO)   l_d = 1'b0;
            if (middle > HI)      m_d = 1'b1;
            else if (middle < LO) m_d = 1'b0;
            if (right > HI)       r_d = 1'b1;
            else if (right < LO)  r_d = 1'b0;
        end
    end

    // Next-state and counter logic; everything advances only on a sample strobe
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        lost_d  = lost_q;
        count_d = node_count;
        flag_d  = 1'b0;
        if (sample_valid) begin
            if (!enable) begin
                state_d = S_IDLE;
                deb_d   = '0;
                hold_d  = '0;
                lost_d  = '0;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_FOLLOW;
                    S_FOLLOW, S_TURN_L, S_TURN_R: begin
                        deb_d  = '0;
                        lost_d = '0;
                        if (pat == 3'b111) begin
                            if (deb_inc == DEB_MAX) begin
                                state_d = S_NODE;
                                flag_d  = 1'b1;
                                count_d = node_count + 1'b1;
                            end else begin
                                deb_d = deb_inc;
                            end
                        end else if (pat == 3'b000) begin
                            if (lost_inc == LOST_MAX) state_d = S_LOST;
                            else                      lost_d  = lost_inc;
                        end else begin
                            case (pat)
                                3'b010:         state_d = S_FOLLOW;
                                3'b100, 3'b110: state_d = S_TURN_L;
                                3'b001, 3'b011: state_d = S_TURN_R;
                                default:        state_d = state_q;
                            endcase
                        end
                    end
                    S_NODE: begin
                        if (hold_inc == HOLD_MAX) begin
                            state_d = S_FOLLOW;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                    S_LOST: if (pat != 3'b000) state_d = S_FOLLOW;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Motor drive decoded from the upcoming state so pins and duty are registered with it
    always_comb begin
        pins_d = 4'b0000;
        dc1_d  = '0;
        dc2_d  = '0;
        case (state_d)
            S_FOLLOW, S_NODE: begin pins_d = 4'b1010; dc1_d = D_FWD;  dc2_d = D_FWD;  end
            S_TURN_L:         begin pins_d = 4'b0110; dc1_d = D_SLOW; dc2_d = D_FAST; end
            S_TURN_R:         begin pins_d = 4'b1001; dc1_d = D_FAST; dc2_d = D_SLOW; end
            default:          begin pins_d = 4'b0000; dc1_d = '0;     dc2_d = '0;     end
        endcase
    end

    // State, counters and all outputs registered; reset aborts anything in progress
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            l_q        <= 1'b0;
            m_q        <= 1'b0;
            r_q        <= 1'b0;
            deb_q      <= '0;
            hold_q     <= '0;
            lost_q     <= '0;
            node_count <= '0;
            node_flag  <= 1'b0;
            lost       <= 1'b0;
            {m1_a, m1_b, m2_a, m2_b} <= 4'b0000;
            dc1        <= '0;
            dc2        <= '0;
        end else begin
            state_q    <= state_d;
            l_q        <= l_d;
            m_q        <= m_d;
            r_q        <= r_d;
            deb_q      <= deb_d;
            hold_q     <= hold_d;
            lost_q     <= lost_d;
            node_count <= count_d;
            node_flag  <= flag_d;
            lost       <= (state_d == S_LOST);
            {m1_a, m1_b, m2_a, m2_b} <= pins_d;
            dc1        <= dc1_d;
            dc2        <= dc2_d;
        end
    end
endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb/tb_line_follow_ctrl.sv - scoreboard bench for line_follow_ctrl
module tb_line_follow_ctrl;
    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] left = '0, middle = '0, right = '0;
    logic        m1_a, m1_b, m2_a, m2_b;
    logic [3:0]  dc1, dc2;
    logic        node_flag;
    logic [7:0]  node_count;
    logic        lost;
    logic [2:0]  state;

    line_follow_ctrl dut (
        .clk_50M(clk_50M), .reset_n(reset_n), .enable(enable), .sample_valid(sample_valid),
        .left(left), .middle(middle), .right(right),
        .m1_a(m1_a), .m1_b(m1_b), .m2_a(m2_a), .m2_b(m2_b),
        .dc1(dc1), .dc2(dc2), .node_flag(node_flag), .node_count(node_count),
        .lost(lost), .state(state)
    );

    always #10 clk_50M = ~clk_50M;

    localparam logic [2:0] IDLE = 3'd0, FOLLOW = 3'd1, TURN_L = 3'd2, TURN_R = 3'd3, NODE = 3'd4, LOST = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       fl;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic exp_due = 1'b0;

    function automatic logic [11:0] drv(input logic [2:0] s);
        case (s)
            FOLLOW, NODE: return {4'b1010, 4'd8, 4'd8};
            TURN_L:       return {4'b0110, 4'd5, 4'd7};
            TURN_R:       return {4'b1001, 4'd7, 4'd5};
            default:      return 12'd0;
        endcase
    endfunction

    function automatic logic [24:0] pack_exp(input exp_t e);
        return {e.st, drv(e.st), e.fl, e.cnt, (e.st == LOST)};
    endfunction

    function automatic logic [24:0] act();
        return {state, m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_flag, node_count, lost};
    endfunction

    // A strobe captured on this edge means the outputs now carry its response
    always @(posedge clk_50M) exp_due <= sample_valid && reset_n;

    // Monitor: pop and compare one expectation per captured sample
    always @(negedge clk_50M) begin
        if (exp_due) begin
            exp_t e;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_underflow: output presented with no expectation, got %h", act());
            end else begin
                e = q.pop_front();
                if (act() !== pack_exp(e)) begin
                    fails++;
                    $display("FAIL sample_resp @%0t: got {st,pins,dc1,dc2,flag,cnt,lost}=%h expected %h",
                             $time, act(), pack_exp(e));
                end
            end
        end
    end

    task automatic send(input int l, input int m, input int r,
                        input logic [2:0] st, input logic fl, input int cnt);
        exp_t e;
        @(posedge clk_50M); #1;
        left = 12'(l); middle = 12'(m); right = 12'(r);
        sample_valid = 1'b1;
        e.st = st; e.fl = fl; e.cnt = 8'(cnt);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_50M); #1;
            sample_valid = 1'b0;
        end
    endtask

    task automatic check_now(input string name, input logic [24:0] expv);
        tests++;
        if (act() !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act(), expv);
        end
    endtask

    initial begin
        exp_t h;
        #25;
        check_now("reset_state", 25'd0);
        @(negedge clk_50M); reset_n = 1'b1;
        enable = 1'b1;
        idle(1);
        check_now("idle_after_reset", 25'd0);

        // Follow, hysteresis and threshold boundaries
        send(100, 900, 100, FOLLOW, 0, 0);
        send(100, 350, 100, FOLLOW, 0, 0);
        send(350, 350, 100, FOLLOW, 0, 0);
        // Turns
        send(900, 100, 100, TURN_L, 0, 0);
        send(100, 100, 900, TURN_R, 0, 0);
        // Node: debounce of 4, then 8 hold samples with P ignored
        repeat (3) send(900, 900, 900, TURN_R, 0, 0);
        send(900, 900, 900, NODE, 1, 1);
        repeat (7) send(900, 900, 900, NODE, 0, 1);
        send(100, 900, 100, FOLLOW, 0, 1);
        // Lost after 16 all-off samples, recovery on any line
        repeat (15) send(100, 100, 100, FOLLOW, 0, 1);
        send(100, 100, 100, LOST, 0, 1);
        send(100, 900, 100, FOLLOW, 0, 1);
        // P=101 holds, exact thresholds hold, 199 clears, 501 sets
        send(900, 100, 900, FOLLOW, 0, 1);
        send(500, 500, 200, FOLLOW, 0, 1);
        send(100, 199, 100, FOLLOW, 0, 1);
        send(100, 501, 100, FOLLOW, 0, 1);
        // Interrupted 111 runs never confirm a node
        repeat (3) send(900, 900, 900, FOLLOW, 0, 1);
        send(100, 900, 100, FOLLOW, 0, 1);
        repeat (3) send(900, 900, 900, FOLLOW, 0, 1);
        send(100, 900, 100, FOLLOW, 0, 1);
        idle(2);
        // enable low forces IDLE on the next sample, node_count kept
        enable = 1'b0;
        send(100, 900, 100, IDLE, 0, 1);
        idle(1);
        enable = 1'b1;
        send(100, 900, 100, FOLLOW, 0, 1);
        // Enter NODE, verify hold without strobes, then async reset
        repeat (3) send(900, 900, 900, FOLLOW, 0, 1);
        send(900, 900, 900, NODE, 1, 2);
        idle(3);
        h.st = NODE; h.fl = 1'b0; h.cnt = 8'd2;
        check_now("hold_no_strobe", pack_exp(h));
        reset_n = 1'b0;
        #2;
        check_now("async_reset_mid_node", 25'd0);
        @(negedge clk_50M); reset_n = 1'b1;
        send(100, 900, 100, FOLLOW, 0, 0);
        // 256 nodes: count wraps to 0
        for (int i = 0; i < 256; i++) begin
            repeat (3) send(900, 900, 900, FOLLOW, 0, i);
            send(900, 900, 900, NODE, 1, (i + 1) % 256);
            repeat (7) send(100, 900, 100, NODE, 0, (i + 1) % 256);
            send(100, 900, 100, FOLLOW, 0, (i + 1) % 256);
        end
        idle(4);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/line_follow_ctrl.md
# line_follow_ctrl

Clocked, parametrised line-following controller for the three-sensor LFA front end. It classifies each ADC sample with hysteresis and runs a motion state machine (follow, pivot left/right, node, lost). It drives the two H-bridge direction pairs and 4-bit PWM duty codes, and emits a debounced node pulse plus a wrapping node counter for the path planner. It sits between the ADC sampler and the PWM generator.

## Interface
- ADC_W, 12, sensor sample width
- TH_HI, 500, reading above this sets a sensor's on-line bit
- TH_LO, 200, reading below this clears the on-line bit; between TH_LO and TH_HI the bit holds
- DUTY_W, 4, duty code width
- DUTY_FWD, 8, duty for both motors when following straight
- DUTY_FAST, 7, outer-wheel duty during a pivot
- DUTY_SLOW, 5, inner-wheel duty during a pivot
- NODE_DEB, 4, consecutive all-on samples needed to confirm a node (≥1)
- NODE_HOLD, 8, samples to drive straight through a confirmed node (≥1)
- LOST_TO, 16, consecutive all-off samples before entering LOST (≥1)
- CNT_W, 8, node counter width

Ports:
- clk_50M  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run; 0 forces IDLE
- sample_valid  in  1  one-cycle strobe; left/middle/right are valid this cycle
- left, middle, right  in  ADC_W  LFA sensor readings
- m1_a, m1_b, m2_a, m2_b  out  1  H-bridge direction pins (m1 = left motor)
- dc1, dc2  out  DUTY_W  left and right duty codes
- node_flag  out  1  one-cycle pulse on node confirmation
- node_count  out  CNT_W  confirmed nodes, wraps modulo 2^CNT_W
- lost  out  1  high while in LOST
- state  out  3  encoded FSM state: IDLE=0, FOLLOW=1, TURN_L=2, TURN_R=3, NODE=4, LOST=5

## Operation
- Classification runs only on sample_valid. For each sensor: bit ← 1 if reading > TH_HI, 0 if reading < TH_LO, else hold. Reading exactly at a threshold holds.
- Pattern P = {l,m,r} uses the bits updated from the current sample.
- Motor drive per state, as {m1_a,m1_b,m2_a,m2_b}, dc1, dc2:
  - IDLE/LOST: 0000, 0, 0
  - FOLLOW/NODE: 1010, DUTY_FWD, DUTY_FWD
  - TURN_L: 0110, DUTY_SLOW, DUTY_FAST
  - TURN_R: 1001, DUTY_FAST, DUTY_SLOW
- Transitions are evaluated on sample_valid only. Precedence is top to bottom.
  - enable=0 forces IDLE from any state. Counters clear; node_count is kept.
  - IDLE with enable=1 → FOLLOW.
  - In FOLLOW, TURN_L or TURN_R:
    - P=111: increment the node debounce counter. When it reaches NODE_DEB: go to NODE, pulse node_flag, increment node_count.
    - P=000: increment the lost counter. When it reaches LOST_TO: go to LOST. Otherwise hold the current state.
    - P=010 → FOLLOW. P=100 or 110 → TURN_L. P=001 or 011 → TURN_R. P=101: hold the current state.
    - Any P≠111 clears the node counter. Any P≠000 clears the lost counter.
  - NODE: count samples. After NODE_HOLD samples → FOLLOW. No new node is detected while in NODE; P is ignored.
  - LOST: any P≠000 → FOLLOW (re-evaluated on the next sample).
- The node debounce is level-qualified. A 111 run longer than NODE_DEB yields exactly one pulse, because NODE is entered.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, all motor pins 0, dc1=dc2=0, node_flag=0, node_count=0, lost=0, sensor bits 0, all counters 0.
- All outputs are registered. Outputs reflect a sample on the clock edge after its sample_valid cycle (latency 1).
- node_flag is high for exactly one clk_50M cycle, coincident with state becoming NODE.
- node_count increments in that same cycle. All-ones wraps to 0.
- Without sample_valid, all state and outputs hold. node_flag returns to 0.
- Back-to-back sample_valid on every cycle is supported.
- reset_n asserted mid-NODE or mid-debounce aborts immediately to reset values.

## Test plan
- Reset then enable, sample (100,900,100) → state=FOLLOW, pins 1010, dc1=dc2=8 one cycle after strobe.
- Hysteresis: middle 900 then 350 → m bit stays 1. Left 350 after 100 → l stays 0. Result: FOLLOW, no turn.
- Left (900,100,100) → TURN_L, pins 0110, dc1=5, dc2=7. Right (100,100,900) → TURN_R, pins 1001, dc1=7, dc2=5.
- Node: 3 samples of all-900 → no pulse. The 4th → node_flag pulse, node_count=1, state=NODE. 6 more 111 samples → no further pulse. After 8 samples → FOLLOW.
- Lost: 16 all-100 samples → lost=1, pins 0000, duty 0. Then (100,900,100) → FOLLOW.
- Wrap: 256 confirmed nodes at CNT_W=8 → node_count=0. Separately, reset_n low during NODE → all outputs 0 asynchronously.
